// File: rtl/br_pred_update_queue.sv
// ---------------------------------------------------------------------------
// br_pred_update_queue
//
// Purpose:
//   Collects branch resolutions from the branch functional unit and turns
//   each one into a predictor training record. A record holds the branch PC,
//   the actual direction, the actual target and a BTB-write flag. Records
//   are buffered in a small in-order FIFO and drained one per handshake to
//   the BHT/BTB update port. This decouples the resolution rate from the
//   availability of the predictor write port.
//
// Parameters:
//   DEPTH     - number of FIFO entries (power of two, >= 2)
//   PC_W      - PC width in bits
//   TRAIN_ALL - 1: enqueue every resolved branch
//               0: enqueue only mispredicted branches
//
// Ports:
//   clk                 clock
//   reset               asynchronous active-low reset
//   br_branch_resolved  resolution valid this cycle (push request)
//   br_pred_taken       direction that was predicted
//   br_pred_dir_wrong   direction was mispredicted
//   br_taken_NPC_wrong  taken branch with a wrong predicted target
//   br_not_taken_NPC    fall-through PC (branch PC + 4)
//   br_recov_NPC        actual next PC
//   flush               synchronous clear of all entries
//   upd_valid           head record available
//   upd_ready           predictor accepts the head this cycle
//   upd_pc              branch PC of the head record
//   upd_taken           actual direction of the head record
//   upd_target          actual target of the head record
//   upd_btb_write       head record requires a BTB write
//   count               current occupancy
//   full                count == DEPTH
//   overflow            sticky: a push was dropped
// ---------------------------------------------------------------------------
module br_pred_update_queue #(
    parameter int DEPTH     = 4,
    parameter int PC_W      = 64,
    parameter int TRAIN_ALL = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    br_branch_resolved,
    input  logic                    br_pred_taken,
    input  logic                    br_pred_dir_wrong,
    input  logic                    br_taken_NPC_wrong,
    input  logic [PC_W-1:0]         br_not_taken_NPC,
    input  logic [PC_W-1:0]         br_recov_NPC,
    input  logic                    flush,
    output logic                    upd_valid,
    input  logic                    upd_ready,
    output logic [PC_W-1:0]         upd_pc,
    output logic                    upd_taken,
    output logic [PC_W-1:0]         upd_target,
    output logic                    upd_btb_write,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PC_W-1:0]  PC_ZERO  = {PC_W{1'b0}};
    localparam logic [PC_W-1:0]  PC_FOUR  = PC_W'(4);
    localparam logic             TRAIN_ALL_BIT = (TRAIN_ALL != 0) ? 1'b1 : 1'b0;

    // Record storage, one array per field
    logic [PC_W-1:0]  pc_mem_r     [DEPTH];
    logic             taken_mem_r  [DEPTH];
    logic [PC_W-1:0]  target_mem_r [DEPTH];
    logic             btb_mem_r    [DEPTH];

    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic             full_r;
    logic             valid_r;
    logic             overflow_r;

    // Record fields formed from the incoming resolution
    logic [PC_W-1:0]  rec_pc_s;
    logic             rec_taken_s;
    logic [PC_W-1:0]  rec_target_s;
    logic             rec_btb_s;

    logic             push_req_s;
    logic             pop_s;
    logic             push_ok_s;
    logic             drop_s;
    logic [CNT_W-1:0] count_nxt_s;

    // Record formation and handshake qualification
    always_comb begin
        rec_pc_s     = br_not_taken_NPC - PC_FOUR;
        rec_taken_s  = br_pred_taken ^ br_pred_dir_wrong;
        rec_target_s = br_recov_NPC;
        rec_btb_s    = br_taken_NPC_wrong;

        push_req_s = br_branch_resolved &
                     (TRAIN_ALL_BIT | br_pred_dir_wrong | br_taken_NPC_wrong);
        pop_s      = valid_r & upd_ready;
        // A pop in the same cycle frees the slot, so a full queue still accepts
        push_ok_s  = push_req_s & (~full_r | pop_s);
        drop_s     = push_req_s & full_r & ~pop_s;
    end

    // Next occupancy from the accepted push/pop pair
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy and the registered status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_r  <= PTR_ZERO;
            tail_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
            full_r  <= 1'b0;
            valid_r <= 1'b0;
        end else if (flush) begin
            head_r  <= PTR_ZERO;
            tail_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
            full_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_FULL);
            valid_r <= (count_nxt_s != CNT_ZERO);
        end
    end

    // Sticky overflow; a push discarded by flush is not a drop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r <= 1'b0;
        end else if (drop_s && !flush) begin
            overflow_r <= 1'b1;
        end
    end

    // Entry storage; cleared on reset so the head reads zero afterwards
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]     <= PC_ZERO;
                taken_mem_r[i]  <= 1'b0;
                target_mem_r[i] <= PC_ZERO;
                btb_mem_r[i]    <= 1'b0;
            end
        end else if (push_ok_s && !flush) begin
            pc_mem_r[tail_r]     <= rec_pc_s;
            taken_mem_r[tail_r]  <= rec_taken_s;
            target_mem_r[tail_r] <= rec_target_s;
            btb_mem_r[tail_r]    <= rec_btb_s;
        end
    end

    // Head fields come straight from storage: no input-to-output path
    assign upd_valid     = valid_r;
    assign upd_pc        = pc_mem_r[head_r];
    assign upd_taken     = taken_mem_r[head_r];
    assign upd_target    = target_mem_r[head_r];
    assign upd_btb_write = btb_mem_r[head_r];
    assign count         = count_r;
    assign full          = full_r;
    assign overflow      = overflow_r;

endmodule

// File: tb/tb_br_pred_update_queue.sv
// ---------------------------------------------------------------------------
// Directed testbench for br_pred_update_queue.
// Instance dut uses TRAIN_ALL=1; instance fdut uses TRAIN_ALL=0 and is only
// pushed during the filtering scenario (its resolved input is separate).
// ---------------------------------------------------------------------------
module tb_br_pred_update_queue;

    logic        clk;
    logic        reset;
    logic        resolved;
    logic        f_resolved;
    logic        pred_taken;
    logic        dir_wrong;
    logic        npc_wrong;
    logic [63:0] nt_npc;
    logic [63:0] recov_npc;
    logic        flush;
    logic        ready;
    logic        f_ready;

    logic        valid;
    logic [63:0] pc;
    logic        taken;
    logic [63:0] target;
    logic        btb;
    logic [2:0]  cnt;
    logic        full;
    logic        ovf;

    logic        f_valid;
    logic [63:0] f_pc;
    logic        f_taken;
    logic [63:0] f_target;
    logic        f_btb;
    logic [2:0]  f_cnt;
    logic        f_full;
    logic        f_ovf;

    int checks = 0;
    int errors = 0;

    br_pred_update_queue #(.DEPTH(4), .PC_W(64), .TRAIN_ALL(1)) dut (
        .clk(clk), .reset(reset),
        .br_branch_resolved(resolved), .br_pred_taken(pred_taken),
        .br_pred_dir_wrong(dir_wrong), .br_taken_NPC_wrong(npc_wrong),
        .br_not_taken_NPC(nt_npc), .br_recov_NPC(recov_npc),
        .flush(flush), .upd_valid(valid), .upd_ready(ready),
        .upd_pc(pc), .upd_taken(taken), .upd_target(target),
        .upd_btb_write(btb), .count(cnt), .full(full), .overflow(ovf)
    );

    br_pred_update_queue #(.DEPTH(4), .PC_W(64), .TRAIN_ALL(0)) fdut (
        .clk(clk), .reset(reset),
        .br_branch_resolved(f_resolved), .br_pred_taken(pred_taken),
        .br_pred_dir_wrong(dir_wrong), .br_taken_NPC_wrong(npc_wrong),
        .br_not_taken_NPC(nt_npc), .br_recov_NPC(recov_npc),
        .flush(flush), .upd_valid(f_valid), .upd_ready(f_ready),
        .upd_pc(f_pc), .upd_taken(f_taken), .upd_target(f_target),
        .upd_btb_write(f_btb), .count(f_cnt), .full(f_full), .overflow(f_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and sample 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a resolution; branch PC p, target t
    task automatic drive(input logic pt, input logic dw, input logic nw,
                         input logic [63:0] p, input logic [63:0] t);
        resolved   = 1'b1;
        pred_taken = pt;
        dir_wrong  = dw;
        npc_wrong  = nw;
        nt_npc     = p + 64'd4;
        recov_npc  = t;
    endtask

    task automatic idle();
        resolved   = 1'b0;
        f_resolved = 1'b0;
        pred_taken = 1'b0;
        dir_wrong  = 1'b0;
        npc_wrong  = 1'b0;
        nt_npc     = 64'd0;
        recov_npc  = 64'd0;
    endtask

    task automatic test_reset();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", cnt); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", ovf); end
        checks++; if (pc !== 64'd0 || target !== 64'd0 || taken !== 1'b0 || btb !== 1'b0) begin
            errors++; $display("FAIL reset_head: got pc=%h tgt=%h tk=%b btb=%b expected zeros", pc, target, taken, btb);
        end
    endtask

    task automatic test_single_push();
        ready = 1'b0;
        resolved = 1'b1; pred_taken = 1'b0; dir_wrong = 1'b1; npc_wrong = 1'b1;
        nt_npc = 64'h1004; recov_npc = 64'h2000;
        tick();
        idle();
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", valid); end
        checks++; if (pc !== 64'h1000) begin errors++; $display("FAIL single_pc: got %h expected 1000", pc); end
        checks++; if (taken !== 1'b1) begin errors++; $display("FAIL single_taken: got %b expected 1", taken); end
        checks++; if (target !== 64'h2000) begin errors++; $display("FAIL single_target: got %h expected 2000", target); end
        checks++; if (btb !== 1'b1) begin errors++; $display("FAIL single_btb: got %b expected 1", btb); end
        checks++; if (cnt !== 3'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", cnt); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++; if (cnt !== 3'd0 || valid !== 1'b0) begin
            errors++; $display("FAIL single_pop: got count=%0d valid=%b expected 0/0", cnt, valid);
        end
    endtask

    task automatic test_order_wrap();
        logic [63:0] exp_pc [4];
        exp_pc[0] = 64'h300; exp_pc[1] = 64'h400; exp_pc[2] = 64'h500; exp_pc[3] = 64'h600;
        ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 64'(i) * 64'h100, 64'(i) * 64'h100 + 64'h40);
            tick();
        end
        idle();
        checks++; if (full !== 1'b1 || cnt !== 3'd4) begin
            errors++; $display("FAIL wrap_fill: got full=%b count=%0d expected 1/4", full, cnt);
        end
        ready = 1'b1;
        tick();
        tick();
        ready = 1'b0;
        checks++; if (cnt !== 3'd2 || pc !== 64'h300) begin
            errors++; $display("FAIL wrap_pop2: got count=%0d pc=%h expected 2/300", cnt, pc);
        end
        drive(1'b1, 1'b0, 1'b0, 64'h500, 64'h540);
        tick();
        drive(1'b1, 1'b0, 1'b0, 64'h600, 64'h640);
        tick();
        idle();
        checks++; if (full !== 1'b1 || cnt !== 3'd4) begin
            errors++; $display("FAIL wrap_full: got full=%b count=%0d expected 1/4", full, cnt);
        end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (pc !== exp_pc[i] || target !== exp_pc[i] + 64'h40 || taken !== 1'b1) begin
                errors++; $display("FAIL wrap_drain%0d: got pc=%h tgt=%h tk=%b expected pc=%h", i, pc, target, taken, exp_pc[i]);
            end
            tick();
        end
        ready = 1'b0;
        checks++; if (valid !== 1'b0 || cnt !== 3'd0) begin
            errors++; $display("FAIL wrap_empty: got valid=%b count=%0d expected 0/0", valid, cnt);
        end
    endtask

    task automatic test_overflow();
        logic [63:0] exp_pc [4];
        exp_pc[0] = 64'h20; exp_pc[1] = 64'h30; exp_pc[2] = 64'h40; exp_pc[3] = 64'h800;
        ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, 64'(i) * 64'h10, 64'h0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b1, 64'h700, 64'h7700);
        tick();
        idle();
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", ovf); end
        checks++; if (cnt !== 3'd4 || pc !== 64'h10) begin
            errors++; $display("FAIL ovf_keep: got count=%0d pc=%h expected 4/10", cnt, pc);
        end
        // Push and pop together while full
        drive(1'b1, 1'b0, 1'b0, 64'h800, 64'h8800);
        ready = 1'b1;
        tick();
        idle();
        ready = 1'b0;
        checks++; if (cnt !== 3'd4 || full !== 1'b1 || pc !== 64'h20) begin
            errors++; $display("FAIL ovf_pushpop: got count=%0d full=%b pc=%h expected 4/1/20", cnt, full, pc);
        end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (pc !== exp_pc[i]) begin
                errors++; $display("FAIL ovf_drain%0d: got pc=%h expected %h", i, pc, exp_pc[i]);
            end
            tick();
        end
        ready = 1'b0;
        checks++; if (ovf !== 1'b1 || cnt !== 3'd0) begin
            errors++; $display("FAIL ovf_sticky: got ovf=%b count=%0d expected 1/0", ovf, cnt);
        end
    endtask

    task automatic test_filtering();
        f_ready = 1'b0;
        f_resolved = 1'b1; pred_taken = 1'b1; dir_wrong = 1'b0; npc_wrong = 1'b0;
        nt_npc = 64'h904; recov_npc = 64'h904;
        tick();
        checks++; if (f_cnt !== 3'd0 || f_valid !== 1'b0) begin
            errors++; $display("FAIL filt_skip: got count=%0d valid=%b expected 0/0", f_cnt, f_valid);
        end
        f_resolved = 1'b1; pred_taken = 1'b1; dir_wrong = 1'b1; npc_wrong = 1'b0;
        nt_npc = 64'hA04; recov_npc = 64'hA04;
        tick();
        idle();
        checks++; if (f_cnt !== 3'd1 || f_pc !== 64'hA00 || f_taken !== 1'b0 || f_btb !== 1'b0) begin
            errors++; $display("FAIL filt_enq: got count=%0d pc=%h tk=%b btb=%b expected 1/a00/0/0", f_cnt, f_pc, f_taken, f_btb);
        end
        f_ready = 1'b1;
        tick();
        f_ready = 1'b0;
        checks++; if (f_cnt !== 3'd0) begin errors++; $display("FAIL filt_pop: got %0d expected 0", f_cnt); end
        checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL filt_main_idle: got %0d expected 0", cnt); end
    endtask

    task automatic test_stability();
        ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 64'hA00, 64'hAAA0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 64'hB00, 64'hBBB0);
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drive(1'b1, 1'b0, 1'b0, 64'hC00, 64'hCCC0);
            else idle();
            tick();
            checks++; if (pc !== 64'hA00 || taken !== 1'b0 || target !== 64'hAAA0 || btb !== 1'b1 || valid !== 1'b1) begin
                errors++; $display("FAIL stable%0d: got pc=%h tk=%b tgt=%h btb=%b expected a00/0/aaa0/1", i, pc, taken, target, btb);
            end
        end
        idle();
        checks++; if (cnt !== 3'd3) begin errors++; $display("FAIL stable_count: got %0d expected 3", cnt); end
    endtask

    task automatic test_flush();
        // Three entries remain from the stability scenario
        drive(1'b1, 1'b0, 1'b0, 64'hD00, 64'hD00);
        ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ready = 1'b0;
        idle();
        checks++; if (cnt !== 3'd0 || valid !== 1'b0 || full !== 1'b0) begin
            errors++; $display("FAIL flush_clear: got count=%0d valid=%b full=%b expected 0/0/0", cnt, valid, full);
        end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL flush_ovf: got %b expected 1", ovf); end
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL flush_hold: got %b expected 0", valid); end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b1, 1'b1, 64'hE00, 64'hEEE0);
        tick();
        idle();
        #2;
        reset = 1'b0;
        #1;
        checks++; if (ovf !== 1'b0 || valid !== 1'b0 || cnt !== 3'd0 || full !== 1'b0) begin
            errors++; $display("FAIL areset_status: got ovf=%b valid=%b count=%0d full=%b expected 0", ovf, valid, cnt, full);
        end
        checks++; if (pc !== 64'd0 || target !== 64'd0 || taken !== 1'b0 || btb !== 1'b0) begin
            errors++; $display("FAIL areset_head: got pc=%h tgt=%h tk=%b btb=%b expected zeros", pc, target, taken, btb);
        end
        #3;
        reset = 1'b1;
        tick();
        tick();
        checks++; if (valid !== 1'b0 || cnt !== 3'd0) begin
            errors++; $display("FAIL areset_after: got valid=%b count=%0d expected 0/0", valid, cnt);
        end
    endtask

    initial begin
        reset   = 1'b0;
        flush   = 1'b0;
        ready   = 1'b0;
        f_ready = 1'b0;
        idle();
        #12;
        test_reset();
        #10;
        reset = 1'b1;
        tick();
        test_single_push();
        test_order_wrap();
        test_overflow();
        test_filtering();
        test_stability();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/br_pred_update_queue.md
Name: br_pred_update_queue

Overview:
- Sits directly downstream of the branch functional unit. Captures the registered resolution outputs the unit produces each cycle.
- Converts each resolution into a predictor training record: branch PC, actual direction, actual target, BTB-write flag.
- Buffers records in a small in-order FIFO and drains them one per handshake to the BHT/BTB update port.
- Decouples branch resolution rate from predictor write-port availability.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- PC_W, 64, PC width in bits.
- TRAIN_ALL, 1, 1 = enqueue every resolved branch; 0 = enqueue only mispredicted branches (pred_dir_wrong or taken_NPC_wrong).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- br_branch_resolved  in  1  resolution valid this cycle (push request).
- br_pred_taken  in  1  direction that was predicted.
- br_pred_dir_wrong  in  1  direction was mispredicted.
- br_taken_NPC_wrong  in  1  branch was taken and the predicted target was wrong.
- br_not_taken_NPC  in  PC_W  fall-through PC (branch PC + 4).
- br_recov_NPC  in  PC_W  actual next PC.
- flush  in  1  synchronous clear of all entries (e.g. exception recovery).
- upd_valid  out  1  head record available.
- upd_ready  in  1  predictor accepts the head this cycle.
- upd_pc  out  PC_W  branch PC of head record.
- upd_taken  out  1  actual direction of head record.
- upd_target  out  PC_W  actual target of head record.
- upd_btb_write  out  1  head record requires a BTB write.
- count  out  clog2(DEPTH)+1  current occupancy.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky flag: a push was dropped.

Behaviour:
- Reset (reset low, asynchronous): head, tail and count = 0; overflow = 0; upd_valid = 0; full = 0. upd_pc, upd_taken, upd_target and upd_btb_write read 0. Entry storage need not be cleared.
- Record formation on push (all combinational from the inputs):
  - pc = br_not_taken_NPC - 4, computed modulo 2^PC_W.
  - taken = br_pred_taken XOR br_pred_dir_wrong.
  - target = br_recov_NPC.
  - btb_write = br_taken_NPC_wrong.
- Push condition: br_branch_resolved AND (TRAIN_ALL OR br_pred_dir_wrong OR br_taken_NPC_wrong).
- Pop condition: upd_valid AND upd_ready.
- FIFO rules:
  - Strict in-order.
  - The record is written at tail on the clock edge; it becomes visible at the head no earlier than the next cycle. There is no fall-through, so minimum latency is 1 cycle.
  - Head outputs come straight from storage.
  - upd_valid = (count != 0).
  - Head record must be held stable while upd_valid is high and upd_ready is low.
- Simultaneous push and pop:
  - Both occur; count is unchanged.
  - Allowed when full: the pop frees the slot, so the push is accepted.
- Push when full without a pop: the incoming record is dropped; stored entries are unchanged; overflow is set and stays set until reset.
- Pop when empty is impossible (upd_valid = 0); upd_ready is ignored.
- Pointers wrap modulo DEPTH. count saturates neither way; by construction it stays within 0..DEPTH.
- flush high at a clock edge:
  - head, tail and count go to 0.
  - Any push or pop in that same cycle is discarded.
  - overflow is unaffected.
  - upd_valid is 0 the following cycle.
- Inputs are sampled only on the rising clock edge. No combinational path from br_* inputs to any output; the only combinational input-to-output path is none (upd_ready affects state only).
- reset asserted mid-operation: immediately empties the queue (async). No update is presented after reset deasserts until a new push.

Test Plan:
- Single push:
  - Stimulus: resolved=1, pred_taken=0, dir_wrong=1, NPC_wrong=1, not_taken_NPC=0x1004, recov_NPC=0x2000, upd_ready=0.
  - Response: next cycle upd_valid=1, upd_pc=0x1000, upd_taken=1, upd_target=0x2000, upd_btb_write=1, count=1.
  - Then raise upd_ready: count=0, upd_valid=0 the following cycle.
- Ordering and wrap:
  - Stimulus: DEPTH=4; push PCs 0x100, 0x200, 0x300, 0x400 (not_taken_NPC +4 each); pop 2; push 0x500, 0x600.
  - Response: full=1; drains in order 0x300, 0x400, 0x500, 0x600.
- Overflow:
  - Stimulus: fill 4 entries with upd_ready=0, push 0x700.
  - Response: overflow=1, count=4, head still first record.
  - Next, push and pop in the same cycle while full: count stays 4 and the new record is at the tail.
- Filtering:
  - Stimulus: TRAIN_ALL=0; push a correctly predicted branch (dir_wrong=0, NPC_wrong=0).
  - Response: count stays 0. A subsequent mispredict is enqueued.
- Flush and reset:
  - Stimulus: 3 entries present; flush together with a push and a pop.
  - Response: count=0, upd_valid=0 next cycle.
  - Then assert reset asynchronously between clock edges: overflow=0 immediately, all outputs at reset values.
- Stability:
  - Stimulus: 2 entries present; hold upd_ready=0 for 5 cycles while pushing 1 more.
  - Response: head fields unchanged across all 5 cycles; count=3.
